jtag_scan_driver: RTL and testbench
===================================

// Module: jtag_scan_driver
// PURPOSE
//  JTAG host-side sequencer. Sits directly upstream of the TAP controller and drives its TMS/TDI.
//  Converts one IR-scan or DR-scan command (length and data) into the TMS/TDI bit stream.
//  Captures TDO during the shift and returns the captured word.
//  The TAP is parked in Run_Test_Idle between commands.
// PARAMETERS
//  MAX_LEN  32  widest scan in bits (cmd_data/rsp_data width)
//  LEN_W    6   width of cmd_len; must satisfy 2**LEN_W > MAX_LEN
// PORTS
//  TCK        in   1        sole clock; all state updates on posedge
//  Reset      in   1        synchronous, active-high
//  cmd_valid  in   1        command offered
//  cmd_ready  out  1        block can accept; transfer = cmd_valid & cmd_ready at posedge
//  cmd_ir     in   1        1 = IR scan, 0 = DR scan
//  cmd_len    in   LEN_W    bits to shift, 1..MAX_LEN
//  cmd_data   in   MAX_LEN  TDI payload, bit 0 shifted first
//  TMS        out  1        to TAP TMS (registered)
//  TDI        out  1        to TAP TDI (registered)
//  TDO        in   1        from TAP serial output
//  rsp_valid  out  1        one-cycle pulse: rsp_data valid; no backpressure
//  rsp_data   out  MAX_LEN  captured TDO, bit i = i-th sampled bit, bits >= len are 0
//  busy       out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset values: TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1. State is INIT.
//  Step: one TMS/TDI value, presented for one full cycle after the posedge that registers it.
//  FSM states: INIT, IDLE, PRE, SHIFT, POST, RESP.
//  - INIT: presents TMS=1 for 5 steps, then TMS=0 for 1 step, then goes to IDLE.
//    This forces the TAP into Test_Logic_Reset and then Run_Test_Idle.
//  - IDLE: TMS=0, TDI=0, cmd_ready=1. On accept, latch cmd_ir, cmd_len and cmd_data, clear rsp_data, go to PRE.
//  - PRE: TMS sequence 1,0,0 for DR, or 1,1,0,0 for IR.
//    This walks the TAP through Select -> Capture -> Shift.
//  - SHIFT: N = latched length. Step i presents TDI=data[i].
//    TMS=0 for i < N-1; TMS=1 on i = N-1, which moves the TAP to Exit1.
//  - TDO sampling: TDO is sampled at the posedge ending step i and stored in rsp_data[i].
//  - POST: TMS sequence 1,0, which takes the TAP through Update to Run_Test_Idle. TDI=0.
//  - RESP: rsp_valid=1 for exactly one cycle; cmd_ready=0. Next state is IDLE.
//  Latency: accept at posedge e0. DR: TMS steps run e0..e(N+4), rsp_valid in the cycle after e(N+5).
//    IR: one cycle more (N+6).
//  cmd_len==0: accepted, no PRE/SHIFT/POST, goes straight to RESP. rsp_valid next cycle, rsp_data=0, TMS stays 0.
//  cmd_len>MAX_LEN: clamped to MAX_LEN.
//  cmd_valid while cmd_ready=0: ignored, not latched. The requester holds the command until the handshake.
//  Inputs cmd_* are don't-care after accept; the latched copy is used.
//  rsp_data: holds its last value until the next accept, which clears it.
//  Reset mid-operation: the scan is abandoned and no rsp_valid is issued.
//    All outputs take their reset values; the INIT sequence re-runs.
//  Counters: one step counter, width max(LEN_W,3). No wrap is possible within a legal command.
// TESTING
//  1 Reset 2 cycles, then release -> TMS=1,1,1,1,1,0; cmd_ready rises after the 6th step.
//    A TAP model attached reads Run_Test_Idle.
//  2 DR scan, len=4, data=0xA, TAP DR=4'h5 -> TDI stream 0,1,0,1; TMS stream 1,0,0,0,0,0,1,1,0.
//    rsp_data=0x5; rsp_valid 9 cycles after accept, 1 cycle wide.
//  3 IR scan, len=4, data=0x3 -> TMS stream 1,1,0,0,0,0,0,1,1,0.
//    TAP IR=0x3 after Update_IR; rsp_valid 10 cycles after accept.
//  4 DR scan, len=32, data=0xDEADBEEF, TAP model in 32-bit loopback holding 0x12345678 -> rsp_data=0x12345678.
//    A second back-to-back DR scan with data=0 returns 0xDEADBEEF.
//  5 cmd_len=0 -> rsp_valid next cycle with rsp_data=0, TMS constant 0.
//    cmd_valid held during busy is not accepted twice.
//  6 Reset asserted mid-SHIFT of a len=16 DR scan -> no rsp_valid.
//    TMS=1 next cycle, INIT re-runs, TAP ends in Run_Test_Idle, cmd_ready=1.

Source files
------------

// File: rtl/jtag_scan_driver.sv
// JTAG host-side scan sequencer.
// Turns one IR or DR scan command into a TMS/TDI bit stream for the TAP.
// Captures TDO during the shift and returns the captured word.
// The TAP is left parked in Run_Test_Idle between commands.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_INIT  | five TMS=1 steps, then one TMS=0 step (TLR -> Run_Test_Idle)
// S_IDLE  | parked in Run_Test_Idle, cmd_ready=1, waiting for a command
// S_PRE   | TMS walk Select -> Capture -> Shift (1,0,0 DR / 1,1,0,0 IR)
// S_SHIFT | one payload bit per step on TDI, TMS=1 on the final bit
// S_POST  | TMS 1,0: Exit1 -> Update -> Run_Test_Idle
// S_RESP  | rsp_valid pulse, then back to S_IDLE
module jtag_scan_driver #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               TCK,
  input  logic               Reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy
);

  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
  localparam logic [CNT_W-1:0] MAX_LEN_C  = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] INIT_STEPS = CNT_W'(5);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ir_q, ir_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic [CNT_W-1:0]   len_in;
  logic [CNT_W-1:0]   len_clamp;

  assign len_in    = CNT_W'(cmd_len);
  assign len_clamp = (len_in > MAX_LEN_C) ? MAX_LEN_C : len_in;

  // Next-state and next-output logic; every output is the registered value
  // of the step that the following cycle presents to the TAP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ir_d        = ir_q;
    data_d      = data_q;
    mask_d      = mask_q;
    rsp_data_d  = rsp_data_q;
    tms_d       = tms_q;
    tdi_d       = 1'b0;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      S_INIT: begin
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          tms_d       = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          // the last INIT step (count 1) drops TMS to leave Test_Logic_Reset
          tms_d = (cnt_q != ONE);
          cnt_d = cnt_q - ONE;
        end
      end

      S_IDLE: begin
        tms_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          ir_d        = cmd_ir;
          len_d       = len_clamp;
          data_d      = cmd_data;
          rsp_data_d  = '0;
          mask_d      = MAX_LEN'(1);
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (len_clamp == '0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
          end else begin
            // first PRE step (TMS=1) goes out on the accept edge itself
            state_d = S_PRE;
            tms_d   = 1'b1;
            cnt_d   = cmd_ir ? CNT_W'(3) : CNT_W'(2);
          end
        end
      end

      S_PRE: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          tms_d   = (len_q == ONE);
          tdi_d   = data_q[0];
          data_d  = data_q >> 1;
          cnt_d   = len_q - ONE;
        end else begin
          // IR walk has one extra TMS=1 (Select_DR -> Select_IR)
          tms_d = ir_q && (cnt_q == CNT_W'(3));
          cnt_d = cnt_q - ONE;
        end
      end

      S_SHIFT: begin
        // this edge ends the step on the wires, so TDO belongs to it
        if (TDO) rsp_data_d = rsp_data_q | mask_q;
        mask_d = mask_q << 1;
        if (cnt_q == '0) begin
          state_d = S_POST;
          tms_d   = 1'b1;
          cnt_d   = ONE;
        end else begin
          tdi_d  = data_q[0];
          data_d = data_q >> 1;
          tms_d  = (cnt_q == ONE);
          cnt_d  = cnt_q - ONE;
        end
      end

      S_POST: begin
        tms_d = 1'b0;
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        tms_d       = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = S_INIT;
        cnt_d       = INIT_STEPS;
        tms_d       = 1'b1;
        cmd_ready_d = 1'b0;
        busy_d      = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset that restarts INIT.
  always_ff @(posedge TCK) begin
    if (Reset) begin
      state_q     <= S_INIT;
      cnt_q       <= INIT_STEPS;
      len_q       <= '0;
      ir_q        <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      rsp_data_q  <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ir_q        <= ir_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      rsp_data_q  <= rsp_data_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_jtag_scan_driver.sv
// Directed bench for jtag_scan_driver with a behavioural TAP controller
// (32-bit loopback DR, 4-bit IR) attached to TMS/TDI/TDO.
module tb_jtag_scan_driver;

  localparam logic [31:0] DR_RESET = 32'h0000_0005;

  logic        TCK = 1'b0;
  logic        Reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_ir;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        TMS;
  logic        TDI;
  logic        TDO = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 TCK = ~TCK;

  jtag_scan_driver #(.MAX_LEN(32), .LEN_W(6)) dut (
    .TCK       (TCK),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // ---------------- TAP controller model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_t;

  tap_t        tap_st  = SH_DR;
  logic [31:0] dr_hold = 32'h0;
  logic [31:0] dr_sr   = 32'h0;
  logic [3:0]  ir_q    = 4'h0;
  logic [3:0]  ir_sr   = 4'h0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge TCK) begin
    case (tap_st)
      TLR:     begin dr_hold <= DR_RESET; ir_q <= 4'hE; end
      CAP_DR:  dr_sr   <= dr_hold;
      SH_DR:   dr_sr   <= {TDI, dr_sr[31:1]};
      UPD_DR:  dr_hold <= dr_sr;
      CAP_IR:  ir_sr   <= 4'b0001;
      SH_IR:   ir_sr   <= {TDI, ir_sr[3:1]};
      UPD_IR:  ir_q    <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, TMS);
  end

  always @(negedge TCK) begin
    TDO <= (tap_st == SH_DR) ? dr_sr[0] : (tap_st == SH_IR) ? ir_sr[0] : 1'b0;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge TCK);
    #1;
  endtask

  // Called one cycle after the last reset edge: expects TMS 1,1,1,1,1,0 then IDLE.
  task automatic init_seq(input string tag);
    logic [5:0] exp_tms;
    exp_tms = 6'b01_1111;
    for (int k = 0; k < 6; k++) begin
      chk({tag, "_tms"}, 64'(TMS), 64'(exp_tms[k]));
      chk({tag, "_rdy_lo"}, 64'(cmd_ready), 64'(0));
      chk({tag, "_no_rsp"}, 64'(rsp_valid), 64'(0));
      step;
    end
    chk({tag, "_rdy_hi"}, 64'(cmd_ready), 64'(1));
    chk({tag, "_busy_lo"}, 64'(busy), 64'(0));
    chk({tag, "_tms_idle"}, 64'(TMS), 64'(0));
    chk({tag, "_tap_rti"}, 64'(tap_st), 64'(RTI));
  endtask

  // One command; lat = edges after the accept edge until rsp_valid is seen.
  task automatic scan(input string tag, input logic ir, input int len,
                      input logic [31:0] data, input logic hold,
                      input logic [31:0] exp_rsp, input int exp_lat,
                      input logic chk_str, input logic [63:0] exp_tms,
                      input logic [63:0] exp_tdi);
    logic [63:0] tms_s;
    logic [63:0] tdi_s;
    int lat;
    tms_s = '0;
    tdi_s = '0;
    lat   = -1;
    chk({tag, "_ready"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_len   = 6'(len);
    cmd_data  = data;
    step;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_ir    = ~ir;
      cmd_len   = 6'd1;
      cmd_data  = ~data;
    end
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      tms_s[k] = TMS;
      tdi_s[k] = TDI;
      step;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_rsp"}, 64'(rsp_data), 64'(exp_rsp));
    chk({tag, "_tms_resp"}, 64'(TMS), 64'(0));
    if (chk_str) begin
      chk({tag, "_tms_stream"}, tms_s, exp_tms);
      chk({tag, "_tdi_stream"}, tdi_s, exp_tdi);
    end
    step;
    chk({tag, "_pulse1"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_hold"}, 64'(rsp_data), 64'(exp_rsp));
    chk({tag, "_ready_again"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ir    = 1'b0;
    cmd_len   = 6'd0;
    cmd_data  = 32'h0;

    // 1: reset values and INIT sequence
    step;
    step;
    chk("rst_tms", 64'(TMS), 64'(1));
    chk("rst_tdi", 64'(TDI), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    Reset = 1'b0;
    init_seq("init");

    // 2: DR len 4, TAP DR holds 0x5 from Test_Logic_Reset
    scan("dr4", 1'b0, 4, 32'hA, 1'b0, 32'h5, 9, 1'b1, 64'h0C1, 64'h050);
    chk("dr4_tap_rti", 64'(tap_st), 64'(RTI));

    // 3: IR len 4, captures 0001, leaves IR=3
    scan("ir4", 1'b1, 4, 32'h3, 1'b0, 32'h1, 10, 1'b1, 64'h183, 64'h030);
    chk("ir4_ir_val", 64'(ir_q), 64'(4'h3));
    chk("ir4_tap_rti", 64'(tap_st), 64'(RTI));

    // 4: 32-bit loopback scans, back to back
    scan("dr32_prime", 1'b0, 32, 32'h1234_5678, 1'b0, 32'hA000_0000, 37, 1'b0, 64'h0, 64'h0);
    scan("dr32_a", 1'b0, 32, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678, 37, 1'b0, 64'h0, 64'h0);
    scan("dr32_b", 1'b0, 32, 32'h0, 1'b0, 32'hDEAD_BEEF, 37, 1'b0, 64'h0, 64'h0);

    // length clamp: 40 behaves as 32
    scan("clamp", 1'b0, 40, 32'h0F0F_0F0F, 1'b0, 32'h0, 37, 1'b0, 64'h0, 64'h0);
    scan("dr8", 1'b0, 8, 32'hFF, 1'b0, 32'h0F, 13, 1'b0, 64'h0, 64'h0);

    // 5: zero length with cmd_valid held through busy
    scan("len0", 1'b0, 0, 32'hFFFF, 1'b1, 32'h0, 0, 1'b0, 64'h0, 64'h0);
    step;
    chk("len0_no_reaccept_busy", 64'(busy), 64'(0));
    chk("len0_no_reaccept_rsp", 64'(rsp_valid), 64'(0));
    chk("len0_tms", 64'(TMS), 64'(0));
    chk("len0_tap_rti", 64'(tap_st), 64'(RTI));

    // held valid across a full DR scan yields one response only
    scan("hold4", 1'b0, 4, 32'h0, 1'b1, 32'hF, 9, 1'b0, 64'h0, 64'h0);
    step;
    chk("hold4_no_reaccept", 64'(busy), 64'(0));

    // 6: reset in the middle of a len 16 DR shift
    cmd_valid = 1'b1;
    cmd_ir    = 1'b0;
    cmd_len   = 6'd16;
    cmd_data  = 32'hBEEF;
    step;
    cmd_valid = 1'b0;
    repeat (5) step;
    chk("abort_in_shift", 64'(tap_st), 64'(SH_DR));
    Reset = 1'b1;
    step;
    chk("abort_tms", 64'(TMS), 64'(1));
    chk("abort_tdi", 64'(TDI), 64'(0));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("abort_rsp_data", 64'(rsp_data), 64'(0));
    chk("abort_busy", 64'(busy), 64'(1));
    chk("abort_ready", 64'(cmd_ready), 64'(0));
    Reset = 1'b0;
    init_seq("reinit");

    scan("post_abort", 1'b0, 8, 32'h3C, 1'b0, 32'h05, 13, 1'b0, 64'h0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
